// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and access helpers for the SRAM slave.
// Imported by ahb_sram_slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  function automatic logic is_illegal(
    input logic [2:0] sz,
    input logic [1:0] off
  );
    case (sz)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Word-organised RAM, one port, byte write enables, async read.
// Contents are deliberately not reset.
module sram_1rw_be #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Byte-lane write on the clock edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of sram_1rw_be with programmable wait states.
// Define AHB_SRAM_ERR_RESP_EN to answer illegal accesses with ERROR.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [MEM_AW-1:0]   waddr_q, waddr_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          size_q, size_d;
  logic                write_q, write_d;
  logic                bad_q, bad_d;

  logic        accept;
  logic        load;
  logic        bad_now;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] rd_shift;
  logic [31:0] rd_lane;
  logic        unused_bits;

  assign unused_bits = ^{haddr[31:MEM_AW+2], htrans[0]};
  assign accept  = hsel & htrans[1] & hready;
  assign bad_now = is_illegal(hsize, haddr[1:0]);

  // State, wait counter and address-phase latches.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      off_q   <= '0;
      size_q  <= SIZE_W;
      write_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
      bad_q   <= bad_d;
    end
  end

  // Next state and bus handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    waddr_d   = waddr_q;
    off_d     = off_q;
    size_d    = size_q;
    write_d   = write_q;
    bad_d     = bad_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    load      = 1'b0;
    unique case (state_q)
      ST_IDLE: load = accept;
      ST_WAIT: begin
        hreadyout = 1'b0;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_DATA;
      end
      ST_DATA: begin
        load = accept;
        if (!accept) state_d = ST_IDLE;
      end
`ifdef AHB_SRAM_ERR_RESP_EN
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      waddr_d = haddr[MEM_AW+1:2];
      off_d   = haddr[1:0];
      size_d  = hsize;
      write_d = hwrite;
      bad_d   = bad_now;
      cnt_d   = WS;
      state_d = (WS != 4'd0) ? ST_WAIT : ST_DATA;
`ifdef AHB_SRAM_ERR_RESP_EN
      if (bad_now) state_d = ST_ERR1;
`endif
    end
  end

  // Lane steering for writes and right-justified reads.
  always_comb begin
    ram_be    = 4'b1111;
    ram_wdata = hwdata;
    rd_shift  = ram_rdata >> {off_q, 3'b000};
    rd_lane   = rd_shift;
    case (size_q)
      SIZE_B: begin
        ram_be    = 4'b0001 << off_q;
        ram_wdata = {4{hwdata[7:0]}};
        rd_lane   = {24'b0, rd_shift[7:0]};
      end
      SIZE_H: begin
        ram_be    = off_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{hwdata[15:0]}};
        rd_lane   = {16'b0, rd_shift[15:0]};
      end
      default: ;
    endcase
    ram_we = (state_q == ST_DATA) & write_q & ~bad_q;
    hrdata = '0;
    if (state_q == ST_DATA && !write_q && !bad_q) hrdata = rd_lane;
  end

  sram_1rw_be #(
    .AW (MEM_AW)
  ) u_ram (
    .clk   (hclk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (waddr_q),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: instance a has no wait states, instance b has two.
// Expectations follow AHB_SRAM_ERR_RESP_EN when defined.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hreset_n = 1'b0;
  logic        hsel = 1'b0;
  logic        sel_b = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd4;
  logic [31:0] hwdata = '0;
  logic        rdy_a, rsp_a, rdy_b, rsp_b;
  logic [31:0] rd_a, rd_b;
  logic        rdy_m, rsp_m;
  logic [31:0] rd_m;
  int          n_vec = 0;
  int          n_bad = 0;

  assign rdy_m = sel_b ? rdy_b : rdy_a;
  assign rsp_m = sel_b ? rsp_b : rsp_a;
  assign rd_m  = sel_b ? rd_b : rd_a;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.MEM_AW(8), .WAIT_STATES(0)) dut_a (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel & ~sel_b),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(rdy_a),
    .hreadyout(rdy_a), .hresp(rsp_a), .hrdata(rd_a)
  );

  ahb_sram_slave #(.MEM_AW(8), .WAIT_STATES(2)) dut_b (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel & sel_b),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(rdy_b),
    .hreadyout(rdy_b), .hresp(rsp_b), .hrdata(rd_b)
  );

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_ph(input logic wr, input logic [31:0] a,
                         input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic xfer(input logic b, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] d,
                      output logic [31:0] r, output int waits,
                      output logic err);
    sel_b = b;
    addr_ph(wr, a, sz);
    cyc();
    idle();
    hwdata = d;
    waits = 0; err = 1'b0; r = 'x;
    forever begin
      @(negedge hclk);
      if (rsp_m) err = 1'b1;
      if (rdy_m) begin r = rd_m; break; end
      waits++;
      if (waits > 20) begin
        n_vec++; n_bad++;
        $display("FAIL xfer_timeout addr=%h", a);
        break;
      end
      @(posedge hclk); #1;
    end
    cyc();
  endtask

  task automatic test_reset();
    @(negedge hclk);
    if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL rst_rdy_a got %b exp 1", rdy_a); end
    if (rsp_a !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_a got %b exp 0", rsp_a); end
    if (rd_a !== 32'h0) begin n_bad++; $display("FAIL rst_rd_a got %h exp 0", rd_a); end
    if (rdy_b !== 1'b1) begin n_bad++; $display("FAIL rst_rdy_b got %b exp 1", rdy_b); end
    if (rsp_b !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_b got %b exp 0", rsp_b); end
    n_vec += 5;
    hreset_n = 1'b1;
    cyc();
  endtask

  task automatic test_word_b2b();
    sel_b = 1'b0;
    addr_ph(1'b1, 32'h20, 3'd4);
    cyc();
    hwdata = 32'hDEADBEEF;
    addr_ph(1'b0, 32'h20, 3'd4);
    @(negedge hclk);
    n_vec += 2;
    if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_rdy got %b exp 1", rdy_a); end
    if (rd_a !== 32'h0) begin n_bad++; $display("FAIL b2b_wr_rdata got %h exp 0", rd_a); end
    cyc();
    idle();
    @(negedge hclk);
    n_vec += 2;
    if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_rdy got %b exp 1", rdy_a); end
    if (rd_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_rd_data got %h exp deadbeef", rd_a); end
    cyc();
    @(negedge hclk);
    n_vec++;
    if (rd_a !== 32'h0) begin n_bad++; $display("FAIL idle_rdata got %h exp 0", rd_a); end
    cyc();
  endtask

  task automatic test_lanes();
    logic [31:0] r;
    int w;
    logic e;
    xfer(1'b0, 1'b1, 32'h40, 3'd4, 32'h11223344, r, w, e);
    xfer(1'b0, 1'b1, 32'h42, 3'd1, 32'h000000AA, r, w, e);
    xfer(1'b0, 1'b0, 32'h40, 3'd4, 32'h0, r, w, e);
    n_vec++;
    if (r !== 32'h11AA3344) begin n_bad++; $display("FAIL lane_word got %h exp 11aa3344", r); end
    xfer(1'b0, 1'b0, 32'h42, 3'd2, 32'h0, r, w, e);
    n_vec++;
    if (r !== 32'h000011AA) begin n_bad++; $display("FAIL lane_half got %h exp 000011aa", r); end
    xfer(1'b0, 1'b0, 32'h43, 3'd1, 32'h0, r, w, e);
    n_vec++;
    if (r !== 32'h00000011) begin n_bad++; $display("FAIL lane_byte got %h exp 00000011", r); end
    xfer(1'b0, 1'b1, 32'h40, 3'd2, 32'h00005566, r, w, e);
    xfer(1'b0, 1'b0, 32'h40, 3'd4, 32'h0, r, w, e);
    n_vec++;
    if (r !== 32'h11AA5566) begin n_bad++; $display("FAIL lane_half_wr got %h exp 11aa5566", r); end
    xfer(1'b0, 1'b0, 32'h40, 3'd1, 32'h0, r, w, e);
    n_vec++;
    if (r !== 32'h00000066) begin n_bad++; $display("FAIL lane_byte0 got %h exp 00000066", r); end
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    int w;
    logic e;
    sel_b = 1'b0;
    addr_ph(1'b0, 32'h41, 3'd4);
    cyc();
    idle();
    @(negedge hclk);
    n_vec += 2;
`ifdef AHB_SRAM_ERR_RESP_EN
    if (rdy_a !== 1'b0) begin n_bad++; $display("FAIL err1_rdy got %b exp 0", rdy_a); end
    if (rsp_a !== 1'b1) begin n_bad++; $display("FAIL err1_rsp got %b exp 1", rsp_a); end
    cyc();
    @(negedge hclk);
    n_vec += 2;
    if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL err2_rdy got %b exp 1", rdy_a); end
    if (rsp_a !== 1'b1) begin n_bad++; $display("FAIL err2_rsp got %b exp 1", rsp_a); end
`else
    if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL bad_rd_rdy got %b exp 1", rdy_a); end
    if (rsp_a !== 1'b0) begin n_bad++; $display("FAIL bad_rd_rsp got %b exp 0", rsp_a); end
    n_vec++;
    if (rd_a !== 32'h0) begin n_bad++; $display("FAIL bad_rd_data got %h exp 0", rd_a); end
`endif
    cyc();
    @(negedge hclk);
    n_vec += 2;
    if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL post_bad_rdy got %b exp 1", rdy_a); end
    if (rsp_a !== 1'b0) begin n_bad++; $display("FAIL post_bad_rsp got %b exp 0", rsp_a); end
    cyc();
    xfer(1'b0, 1'b1, 32'h42, 3'd4, 32'hFFFFFFFF, r, w, e);
    n_vec++;
`ifdef AHB_SRAM_ERR_RESP_EN
    if (e !== 1'b1) begin n_bad++; $display("FAIL bad_wr_err got %b exp 1", e); end
`else
    if (e !== 1'b0) begin n_bad++; $display("FAIL bad_wr_err got %b exp 0", e); end
`endif
    xfer(1'b0, 1'b1, 32'h40, 3'd3, 32'hFFFFFFFF, r, w, e);
    xfer(1'b0, 1'b1, 32'h41, 3'd2, 32'hFFFFFFFF, r, w, e);
    xfer(1'b0, 1'b0, 32'h40, 3'd4, 32'h0, r, w, e);
    n_vec++;
    if (r !== 32'h11AA5566) begin n_bad++; $display("FAIL bad_wr_ram got %h exp 11aa5566", r); end
  endtask

  task automatic test_wait_states();
    logic [31:0] r;
    logic [31:0] exp_d [2];
    int w;
    logic e;
    exp_d[0] = 32'hCAFEF00D;
    exp_d[1] = 32'h0BADC0DE;
    xfer(1'b1, 1'b1, 32'h30, 3'd4, exp_d[0], r, w, e);
    n_vec++;
    if (w !== 2) begin n_bad++; $display("FAIL ws_write_waits got %0d exp 2", w); end
    xfer(1'b1, 1'b1, 32'h34, 3'd4, exp_d[1], r, w, e);
    sel_b = 1'b1;
    addr_ph(1'b0, 32'h30, 3'd4);
    cyc();
    addr_ph(1'b0, 32'h34, 3'd4);
    for (int k = 0; k < 2; k++) begin
      w = 0;
      forever begin
        @(negedge hclk);
        if (rdy_b) break;
        n_vec++;
        if (rd_b !== 32'h0) begin n_bad++; $display("FAIL ws_wait_rdata got %h exp 0", rd_b); end
        w++;
        if (w > 20) break;
        @(posedge hclk); #1;
      end
      n_vec += 2;
      if (w !== 2) begin n_bad++; $display("FAIL ws_waits[%0d] got %0d exp 2", k, w); end
      if (rd_b !== exp_d[k]) begin n_bad++; $display("FAIL ws_data[%0d] got %h exp %h", k, rd_b, exp_d[k]); end
      cyc();
      idle();
    end
    @(negedge hclk);
    n_vec++;
    if (rdy_b !== 1'b1) begin n_bad++; $display("FAIL ws_idle_rdy got %b exp 1", rdy_b); end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int w;
    logic e;
    xfer(1'b1, 1'b1, 32'h10, 3'd4, 32'h12345678, r, w, e);
    sel_b = 1'b1;
    addr_ph(1'b1, 32'h10, 3'd4);
    cyc();
    idle();
    hwdata = 32'hFFFFFFFF;
    #1;
    n_vec++;
    if (rdy_b !== 1'b0) begin n_bad++; $display("FAIL mid_pre_rdy got %b exp 0", rdy_b); end
    hreset_n = 1'b0;
    #1;
    n_vec += 3;
    if (rdy_b !== 1'b1) begin n_bad++; $display("FAIL mid_rst_rdy got %b exp 1", rdy_b); end
    if (rsp_b !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rsp got %b exp 0", rsp_b); end
    if (rd_b !== 32'h0) begin n_bad++; $display("FAIL mid_rst_rd got %h exp 0", rd_b); end
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hreset_n = 1'b1;
    cyc();
    xfer(1'b1, 1'b0, 32'h10, 3'd4, 32'h0, r, w, e);
    n_vec++;
    if (r !== 32'h12345678) begin n_bad++; $display("FAIL mid_rst_ram got %h exp 12345678", r); end
  endtask

  task automatic test_unselected();
    logic [31:0] r;
    int w;
    logic e;
    xfer(1'b0, 1'b1, 32'h80, 3'd4, 32'h13572468, r, w, e);
    sel_b = 1'b0;
    hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h80;
    hsize = 3'd4;
    cyc();
    hsel = 1'b1; htrans = 2'b00;
    hwdata = 32'hFFFFFFFF;
    @(negedge hclk);
    n_vec += 2;
    if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL unsel_rdy got %b exp 1", rdy_a); end
    if (rsp_a !== 1'b0) begin n_bad++; $display("FAIL unsel_rsp got %b exp 0", rsp_a); end
    cyc();
    htrans = 2'b01;
    cyc();
    idle();
    @(negedge hclk);
    n_vec++;
    if (rdy_a !== 1'b1) begin n_bad++; $display("FAIL idle_sel_rdy got %b exp 1", rdy_a); end
    cyc();
    xfer(1'b0, 1'b0, 32'h80, 3'd4, 32'h0, r, w, e);
    n_vec++;
    if (r !== 32'h13572468) begin n_bad++; $display("FAIL unsel_ram got %h exp 13572468", r); end
  endtask

  initial begin
    repeat (3) @(posedge hclk);
    test_reset();
    test_word_b2b();
    test_lanes();
    test_illegal();
    test_wait_states();
    test_reset_mid();
    test_unselected();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave that fronts an on-chip word-organised data RAM.
- Sits directly downstream of the core's AHB-Lite master and services its single NONSEQ transfers.
- Uses a two-phase pipeline (address phase, then data phase) with a programmable number of wait states.
- Handles byte, halfword and word accesses using the core's right-justified data convention.

Parameters:
- MEM_AW, 12: word-address width; RAM holds 2**MEM_AW 32-bit words; haddr[MEM_AW+1:2] indexes it and upper bits are ignored (the decoder handles them).
- WAIT_STATES, 0: number of extra data-phase cycles with hreadyout low per transfer; range 0..15.

Ports:
- hclk  in  1  bus clock
- hreset_n  in  1  asynchronous active-low reset
- hsel  in  1  slave select from the address decoder
- haddr  in  32  byte address (address phase)
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1 = write
- hsize  in  3  access size as a byte count: 1 = byte, 2 = halfword, 4 = word
- hwdata  in  32  write data (data phase), right-justified
- hready  in  1  bus-wide ready; an address phase is accepted only when this is high
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  32  read data, right-justified and zero-extended

Behaviour:
- Reset (async assert, sync release): hreadyout=1, hresp=0, hrdata=0, state=IDLE, wait counter=0. RAM contents are not reset.
- A reset asserted mid-transfer aborts the transfer; a pending write is dropped.
- Accept condition: hsel && htrans[1] && hready at a rising edge. On acceptance, latch addr, write, size and the wait count.
- IDLE/BUSY with hsel high, or hsel low: no acceptance; the slave returns a zero-wait OKAY.
- States:
  - IDLE: on accept, go to WAIT if WAIT_STATES>0, else DATA. On accept of an illegal access, go to ERR1.
  - WAIT: hreadyout=0; decrement the counter; go to DATA when it reaches 1.
  - DATA: hreadyout=1, hresp=0; this is the final data-phase cycle.
    - Write: commit at this cycle's rising edge using the current hwdata.
    - Read: hrdata is valid this cycle.
    - A new accept in the same cycle is allowed (pipelined) and goes to WAIT, DATA or ERR1 as from IDLE. Otherwise go to IDLE.
  - ERR1: hreadyout=0, hresp=1; go to ERR2.
  - ERR2: hreadyout=1, hresp=1. Accepts in this cycle are ignored (the master cancels them); go to IDLE.
- Latency: read data is valid WAIT_STATES+1 cycles after the address-phase edge. Throughput is one transfer per WAIT_STATES+1 cycles.
- RAM read is asynchronous from the latched word address.
  - Read-after-write to the same address back-to-back returns the new data, with no forwarding needed.
- Lane rules, with off = latched addr[1:0]:
  - Byte: write hwdata[7:0] to byte lane off; read returns {24'b0, lane off}.
  - Halfword: off[0] must be 0; lanes off and off+1 map to bits [15:0].
  - Word: off must be 00.
- Illegal accesses: hsize not in {1,2,4}, or misaligned per the lane rules. Behaviour is set by the optional feature below.
- hrdata=0 in every cycle other than a read DATA cycle.

Optional Feature:
- Macro AHB_SRAM_ERR_RESP_EN.
- Defined: an illegal access takes the two-cycle ERROR response (ERR1, ERR2) and the RAM is untouched.
- Undefined: an illegal access is treated as legal timing-wise (WAIT/DATA with OKAY), the write is dropped and the read returns 0. ERR states are not synthesised.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/ERROR
  - SIZE_B=3'd1, SIZE_H=3'd2, SIZE_W=3'd4
  - state encoding for IDLE/WAIT/DATA/ERR1/ERR2
- Sub-module sram_1rw_be contains the RAM array: 2**MEM_AW x 32, 4-bit byte-write-enable, async read.
- The FSM, lane shifting and merging stay in ahb_sram_slave.

Test Plan:
- Reset then idle: hreset_n low mid-WAIT -> hreadyout=1, hresp=0, hrdata=0 immediately; the write to 0x10 does not occur (later read of 0x10 returns the old value).
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x20, then read 0x20 back-to-back -> hreadyout stays 1 and hrdata=0xDEADBEEF in the read data phase.
- Byte/halfword lanes: word 0x11223344 at 0x40; byte write 0xAA to 0x42 -> word reads 0x11AA3344; halfword read at 0x42 -> 0x000011AA; byte read at 0x43 -> 0x00000011.
- Wait states, WAIT_STATES=2: word read -> hreadyout low for exactly 2 cycles, then high with data; a pipelined next address is accepted only on the hready-high edge.
- Illegal access with AHB_SRAM_ERR_RESP_EN: word read at 0x41 -> hreadyout 0 with hresp 1, then hreadyout 1 with hresp 1, then OKAY. Without the macro: OKAY with hrdata=0, and a misaligned write leaves the RAM unchanged.
- Non-selected or IDLE traffic: hsel=0 with NONSEQ write to 0x80 -> RAM unchanged, hreadyout=1, hresp=0.
